mips_mem_responder: RTL and testbench

Memory-side responder for the MIPS32 core's load/store and fetch path. Serves word-addressed read/write requests from an initiator over a valid/ready request channel. Returns one in-order response per request over a valid/ready response channel, after a fixed pipeline latency. Replaces the core's internal Mem[] array, so the memory can be shared or back-pressured.

---
 rtl/mips_mem_pkg.sv | 22 ++
 rtl/mips_resp_fifo.sv | 67 ++++++
 rtl/mips_mem_responder.sv | 137 +++++++++++++
 tb/tb_mips_mem_responder.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_mem_pkg.sv
// Shared types and defaults for the MIPS32 memory responder.
// Holds the response record, size defaults and the address range check.
package mips_mem_pkg;

    localparam int DEFAULT_DEPTH      = 1024;
    localparam int DEFAULT_LATENCY    = 2;
    localparam int DEFAULT_RESP_DEPTH = 4;

    typedef struct packed {
        logic        we;
        logic        err;
        logic [31:0] rdata;
    } resp_t;

    // The full 32-bit word address is compared, so aliases above DEPTH
    // are flagged rather than silently folded onto low memory.
    function automatic logic addr_in_range(input logic [31:0] addr,
                                           input int unsigned depth);
        return addr < depth;
    endfunction

endpackage

// File: rtl/mips_resp_fifo.sv
// In-order synchronous FIFO for responses, with an occupancy count.
// Ports: clk1, rst_n, push/wdata, pop/rdata, empty, full, count.
module mips_resp_fifo #(
    parameter int WIDTH = 34,
    parameter int DEPTH = 4,
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CW = $clog2(DEPTH + 1)
) (
    input  logic             clk1,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata,
    output logic             empty,
    output logic             full,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] store [DEPTH];
    logic [PW-1:0]    rd_q;
    logic [PW-1:0]    wr_q;
    logic [CW-1:0]    cnt_q;
    logic             pop_ok;
    logic             push_ok;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty = (cnt_q == '0);
    assign full  = (cnt_q == CW'(DEPTH));
    assign count = cnt_q;
    assign rdata = store[rd_q];

    // A push into a full FIFO is accepted only when a pop frees the
    // head slot on the same edge.
    assign pop_ok  = pop && !empty;
    assign push_ok = push && (!full || pop_ok);

    always_ff @(posedge clk1) begin
        if (push_ok) begin
            store[wr_q] <= wdata;
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            if (pop_ok) begin
                rd_q <= ptr_inc(rd_q);
            end
            if (push_ok) begin
                wr_q <= ptr_inc(wr_q);
            end
            unique case ({push_ok, pop_ok})
                2'b10:   cnt_q <= cnt_q + 1'b1;
                2'b01:   cnt_q <= cnt_q - 1'b1;
                default: cnt_q <= cnt_q;
            endcase
        end
    end

endmodule

// File: rtl/mips_mem_responder.sv
// Word-addressed memory responder for the MIPS32 load/store/fetch path.
// Ports: clk1, rst_n, req_{valid,ready,we,addr,wdata},
//        resp_{valid,ready,rdata,we,err}.
module mips_mem_responder
    import mips_mem_pkg::*;
#(
    parameter int DEPTH      = DEFAULT_DEPTH,
    parameter int LATENCY    = DEFAULT_LATENCY,
    parameter int RESP_DEPTH = DEFAULT_RESP_DEPTH
) (
    input  logic        clk1,
    input  logic        rst_n,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    input  logic        resp_ready,
    output logic [31:0] resp_rdata,
    output logic        resp_we,
    output logic        resp_err
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(RESP_DEPTH + 1);

    logic [31:0]        mem [DEPTH];

    logic               accept;
    logic               pop;
    logic               in_range;
    logic [AW-1:0]      idx;
    resp_t              acc_rec;

    logic [LATENCY-1:0] pv;
    resp_t              pd [LATENCY];

    logic [CW-1:0]      out_q;
    logic [CW-1:0]      out_nxt;
    logic               ready_q;

    resp_t              head;
    logic               fifo_empty;
    logic               fifo_full;
    logic [CW-1:0]      fifo_count;
    logic               fifo_unused;

    assign req_ready = ready_q;
    assign accept    = req_valid && ready_q;
    assign pop       = resp_valid && resp_ready;
    assign in_range  = addr_in_range(req_addr, DEPTH);
    assign idx       = req_addr[AW-1:0];

    always_comb begin
        acc_rec       = '0;
        acc_rec.we    = req_we;
        acc_rec.err   = !in_range;
        if (!req_we && in_range) begin
            acc_rec.rdata = mem[idx];
        end
    end

    // Stores commit on their acceptance edge; a later load reads the
    // updated word. Contents survive reset.
    always_ff @(posedge clk1) begin
        if (accept && req_we && in_range) begin
            mem[idx] <= req_wdata;
        end
    end

    // Payload stages need no reset: only the valid bits gate them.
    always_ff @(posedge clk1) begin
        pd[0] <= acc_rec;
        for (int i = 1; i < LATENCY; i++) begin
            pd[i] <= pd[i-1];
        end
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            pv <= '0;
        end else begin
            pv[0] <= accept;
            for (int i = 1; i < LATENCY; i++) begin
                pv[i] <= pv[i-1];
            end
        end
    end

    // Credits: every accepted request owns a FIFO slot until popped,
    // so the pipeline can never overrun the FIFO.
    always_comb begin
        out_nxt = out_q;
        unique case ({accept, pop})
            2'b10:   out_nxt = out_q + 1'b1;
            2'b01:   out_nxt = out_q - 1'b1;
            default: out_nxt = out_q;
        endcase
    end

    // Ready is registered from the next credit count, so it has no
    // combinational dependency on req_valid or resp_ready.
    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            out_q   <= '0;
            ready_q <= 1'b0;
        end else begin
            out_q   <= out_nxt;
            ready_q <= (out_nxt < CW'(RESP_DEPTH));
        end
    end

    mips_resp_fifo #(
        .WIDTH ($bits(resp_t)),
        .DEPTH (RESP_DEPTH)
    ) u_fifo (
        .clk1  (clk1),
        .rst_n (rst_n),
        .push  (pv[LATENCY-1]),
        .wdata (pd[LATENCY-1]),
        .pop   (pop),
        .rdata (head),
        .empty (fifo_empty),
        .full  (fifo_full),
        .count (fifo_count)
    );

    assign fifo_unused = fifo_full ^ (^fifo_count);

    // Outputs read as zero whenever no response is presented.
    assign resp_valid = !fifo_empty;
    assign resp_rdata = resp_valid ? head.rdata : '0;
    assign resp_we    = resp_valid && head.we;
    assign resp_err   = resp_valid && head.err;

endmodule

// File: tb/tb_mips_mem_responder.sv
// Randomised bench for mips_mem_responder against a queue-based model.
// Directed scenarios plus a random traffic phase.
module tb_mips_mem_responder;

    localparam int DEPTH = 1024;
    localparam int LAT   = 2;
    localparam int RD    = 4;

    logic        clk1 = 1'b0;
    logic        rst_n = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_we = 1'b0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_rdata;
    logic        resp_we;
    logic        resp_err;

    mips_mem_responder #(
        .DEPTH      (DEPTH),
        .LATENCY    (LAT),
        .RESP_DEPTH (RD)
    ) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_we     (req_we),
        .req_addr   (req_addr),
        .req_wdata  (req_wdata),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_rdata (resp_rdata),
        .resp_we    (resp_we),
        .resp_err   (resp_err)
    );

    always #5 clk1 = ~clk1;

    typedef struct {
        int          due;
        bit          we;
        bit          err;
        logic [31:0] rdata;
    } exp_t;

    exp_t        q[$];
    logic [31:0] mm [DEPTH];
    int          mdl_out;
    bit          mdl_ready;
    int          cyc;
    int          n_checks;
    int          n_errors;
    int          acc_cnt;
    bit          rec_en;
    logic [31:0] rx[$];
    int          rxc[$];

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)",
                     tag, got, exp, cyc);
        end
    endtask

    function automatic bit head_visible();
        return (q.size() > 0) && (q[0].due <= cyc);
    endfunction

    task automatic check_outputs();
        bit ev;
        ev = head_visible();
        chk("req_ready", 32'(req_ready), 32'(mdl_ready));
        chk("resp_valid", 32'(resp_valid), 32'(ev));
        if (ev) begin
            chk("resp_rdata", resp_rdata, q[0].rdata);
            chk("resp_we", 32'(resp_we), 32'(q[0].we));
            chk("resp_err", 32'(resp_err), 32'(q[0].err));
        end
    endtask

    task automatic step();
        bit   ev;
        bit   acc;
        bit   pop;
        exp_t e;
        int   ix;
        ev = head_visible();
        if (req_valid && req_ready) acc_cnt++;
        if (rec_en && resp_valid && resp_ready) begin
            rx.push_back(resp_rdata);
            rxc.push_back(cyc);
        end
        @(posedge clk1);
        cyc++;
        if (rst_n) begin
            pop = ev && resp_ready;
            acc = req_valid && mdl_ready;
            if (pop) void'(q.pop_front());
            if (acc) begin
                e.due   = cyc + LAT;
                e.we    = req_we;
                e.err   = (req_addr >= DEPTH);
                e.rdata = '0;
                ix      = int'(req_addr % DEPTH);
                if (req_we && !e.err) mm[ix] = req_wdata;
                if (!req_we && !e.err) e.rdata = mm[ix];
                q.push_back(e);
            end
            mdl_out   = mdl_out + int'(acc) - int'(pop);
            mdl_ready = (mdl_out < RD);
        end else begin
            mdl_ready = 1'b0;
        end
        #1;
        check_outputs();
    endtask

    task automatic drive(input bit v, input bit we,
                         input logic [31:0] a, input logic [31:0] d);
        req_valid = v;
        req_we    = we;
        req_addr  = a;
        req_wdata = d;
    endtask

    task automatic drain();
        int n;
        drive(0, 0, 0, 0);
        resp_ready = 1'b1;
        n = 0;
        while (q.size() > 0 && n < 50) begin
            step();
            n++;
        end
        chk("drain_done", 32'(q.size()), 32'd0);
    endtask

    task automatic reset_async();
        #2;
        rst_n = 1'b0;
        q.delete();
        mdl_out   = 0;
        mdl_ready = 1'b0;
        #1;
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_resp_rdata", resp_rdata, 32'd0);
        chk("rst_resp_we", 32'(resp_we), 32'd0);
        chk("rst_resp_err", 32'(resp_err), 32'd0);
        drive(0, 0, 0, 0);
        repeat (2) step();
        @(negedge clk1);
        rst_n = 1'b1;
        step();
    endtask

    initial begin
        logic [31:0] saved;
        logic [31:0] v;
        bit          we;
        logic [31:0] a;

        n_checks = 0;
        n_errors = 0;
        cyc      = 0;
        acc_cnt  = 0;
        rec_en   = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            v          = $urandom;
            mm[i]      = v;
            dut.mem[i] = v;
        end

        // Reset from time zero, including a real falling edge.
        #1;
        reset_async();

        // Store then load of the same word.
        resp_ready = 1'b1;
        drive(1, 1, 32'd5, 32'hDEADBEEF);
        step();
        drive(1, 0, 32'd5, 32'd0);
        step();
        drain();
        chk("t1_mem5", dut.mem[5], 32'hDEADBEEF);

        // Back-pressure: only RESP_DEPTH loads get in.
        resp_ready = 1'b0;
        acc_cnt    = 0;
        for (int i = 0; i < 8; i++) begin
            drive(1, 0, 32'(100 + i), 32'd0);
            step();
        end
        chk("t2_accepted", 32'(acc_cnt), 32'(RD));
        chk("t2_ready_low", 32'(req_ready), 32'd0);
        drain();

        // Streaming loads with known contents.
        for (int i = 0; i < 20; i++) begin
            mm[i]      = 32'(i * 3);
            dut.mem[i] = 32'(i * 3);
        end
        rx.delete();
        rxc.delete();
        rec_en     = 1'b1;
        resp_ready = 1'b1;
        for (int i = 0; i < 20; i++) begin
            drive(1, 0, 32'(i), 32'd0);
            step();
        end
        drain();
        step();
        rec_en = 1'b0;
        chk("t3_count", 32'(rx.size()), 32'd20);
        if (rx.size() == 20) begin
            for (int i = 0; i < 20; i++) begin
                chk("t3_rdata", rx[i], 32'(i * 3));
            end
            chk("t3_no_bubble", 32'(rxc[19] - rxc[0]), 32'd19);
        end

        // Out-of-range load and store.
        saved = mm[976];
        drive(1, 0, 32'd1024, 32'd0);
        step();
        drive(1, 1, 32'd2000, 32'd1);
        step();
        drain();
        chk("t4_mem976", dut.mem[976], saved);

        // Reset while requests are in flight.
        resp_ready = 1'b0;
        v = $urandom;
        drive(1, 1, 32'd77, v);
        step();
        drive(1, 0, 32'd3, 32'd0);
        step();
        drive(1, 0, 32'd4, 32'd0);
        step();
        reset_async();
        chk("t5_outstanding", 32'(dut.out_q), 32'd0);
        resp_ready = 1'b1;
        repeat (3) step();
        drive(1, 0, 32'd77, 32'd0);
        step();
        drain();
        chk("t5_mem77", mm[77], v);

        // Random traffic with a narrow address window for hazards.
        for (int i = 0; i < 600; i++) begin
            we = ($urandom_range(0, 2) == 0);
            if ($urandom_range(0, 9) == 0)
                a = 32'($urandom_range(1024, 4095));
            else
                a = 32'($urandom_range(0, 31));
            drive($urandom_range(0, 4) != 0, we, a, $urandom);
            resp_ready = ((i / 40) % 3 == 1) ? 1'b0
                       : ($urandom_range(0, 3) != 0);
            step();
        end
        drain();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
